// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
// Holds the loader FSM state encoding and the word geometry:
//   DATA_W         - instruction word width in bits (fixed at 16)
//   BYTES_PER_WORD - bytes streamed per instruction word (low byte first)
package loader_pkg;

  localparam int DATA_W         = 16;
  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_DAT_HI = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// Signals:
//   in_valid  - upstream byte valid
//   in_data   - upstream byte
//   in_ready  - loader accepts a byte (transfer when in_valid && in_ready)
//   mem_we    - one-cycle write strobe per assembled word
//   mem_addr  - word address of the write
//   mem_wdata - 16-bit word of the write
// Modports: master = the loader, slave = the source/memory side.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  import loader_pkg::*;

  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// word_assembler: collects the low and high byte of an instruction word.
// Ports:
//   clk, reset - clock and asynchronous active-low reset
//   lo_en      - capture in_data as the low byte
//   hi_en      - capture in_data as the high byte and publish the word
//   in_data    - incoming byte
//   word       - last completed word {hi, lo}
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              lo_en,
  input  logic              hi_en,
  input  logic [7:0]        in_data,
  output logic [DATA_W-1:0] word
);

  logic [7:0]        lo_q;
  logic [DATA_W-1:0] word_q;

  // The published word only changes when the high byte lands, so it stays
  // stable while the next word's low byte is being collected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q   <= '0;
      word_q <= '0;
    end else begin
      if (lo_en) lo_q <= in_data;
      if (hi_en) word_q <= {in_data, lo_q};
    end
  end

  assign word = word_q;

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte stream, writes the words
// into instruction memory and then releases the CPU.
// Stream: 16-bit word count N (lo, hi), then N words (lo, hi each).
// Ports:
//   clk     - clock, all state changes on the rising edge
//   reset   - asynchronous, active-low
//   start   - one-cycle pulse, begins a load from IDLE, DONE or ERROR
//   cpu_run - 1 only in DONE
//   busy    - 1 in any state other than IDLE, DONE or ERROR
//   err     - 1 only in ERROR (word count too large)
//   bus     - byte stream and memory write bus (master side)
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             cpu_run,
  output logic             busy,
  output logic             err,
  program_loader_if.master bus
);

  // Largest legal word count is the full memory depth; 17 bits so that
  // ADDR_W = 16 still fits.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [15:0]       n_q;
  logic [15:0]       count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       len_word;
  logic [15:0]       count_next;
  logic              xfer;
  logic              start_load;

  assign bus.in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DAT_LO) || (state_q == S_DAT_HI);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign start_load   = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                  (state_q == S_ERROR));
  assign len_word     = {bus.in_data, len_lo_q};
  assign count_next   = count_q + 16'd1;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the length decision uses the high byte as it arrives
  // so that DONE/ERROR is entered right after the second length byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start_load) state_d = S_LEN_LO;
      S_LEN_LO: if (xfer) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (len_word == 16'd0)                 state_d = S_DONE;
          else if ({1'b0, len_word} > MAX_WORDS) state_d = S_ERROR;
          else                                   state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: if (xfer) state_d = S_DAT_HI;
      S_DAT_HI: if (xfer) state_d = S_WRITE;
      S_WRITE:  state_d = (count_next == n_q) ? S_DONE : S_DAT_LO;
      default:  state_d = S_IDLE;
    endcase
  end

  // Length, word counter and address. The write address is captured with
  // the high byte so mem_addr holds its value between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo_q   <= '0;
      n_q        <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
    end else begin
      if (start_load) begin
        count_q <= '0;
        addr_q  <= '0;
      end
      if (xfer && state_q == S_LEN_LO) len_lo_q <= bus.in_data;
      if (xfer && state_q == S_LEN_HI) n_q <= len_word;
      if (xfer && state_q == S_DAT_HI) mem_addr_q <= addr_q;
      if (state_q == S_WRITE) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_next;
      end
    end
  end

  word_assembler u_word_assembler (
    .clk     (clk),
    .reset   (reset),
    .lo_en   (xfer && state_q == S_DAT_LO),
    .hi_en   (xfer && state_q == S_DAT_HI),
    .in_data (bus.in_data),
    .word    (bus.mem_wdata)
  );

  assign bus.mem_we   = (state_q == S_WRITE);
  assign bus.mem_addr = mem_addr_q;
  assign cpu_run      = (state_q == S_DONE);
  assign err          = (state_q == S_ERROR);
  assign busy         = !((state_q == S_IDLE) || (state_q == S_DONE) ||
                          (state_q == S_ERROR));

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader with ADDR_W = 8.
module tb_program_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_run, busy, err;

  int vectors = 0;
  int miscompares = 0;

  program_loader_if #(.ADDR_W(8)) bus ();

  program_loader #(.ADDR_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cpu_run (cpu_run),
    .busy    (busy),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Write recorder
  logic [7:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  int          ready_in_write = 0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      if (bus.in_ready) ready_in_write++;
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    ready_in_write = 0;
  endtask

  // Called just after a negedge; returns at the negedge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tries = 0;
    while (!bus.in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL handshake_timeout byte=%02h in_ready never rose", b);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.mem_we, cpu_run, busy, err} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got=%b want=00000",
               {bus.in_ready, bus.mem_we, cpu_run, busy, err});
    end
    vectors++;
    if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_bus got addr=%h data=%h want 00/0000",
               bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] s[6] = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    clear_log();
    pulse_start();
    vectors++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_len_lo got busy=%b rdy=%b want 1/1", busy, bus.in_ready);
    end
    foreach (s[i]) send_byte(s[i], 0);
    @(negedge clk);
    vectors++;
    if (wr_addr.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL basic_count got=%0d want=2", wr_addr.size());
    end else begin
      vectors++;
      if (wr_addr[0] !== 8'd0 || wr_data[0] !== 16'h1234 ||
          wr_addr[1] !== 8'd1 || wr_data[1] !== 16'h5678) begin
        miscompares++;
        $display("[TB] FAIL basic_writes got %h@%h %h@%h want 1234@00 5678@01",
                 wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
      end
    end
    vectors++;
    if (cpu_run !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_done got run=%b busy=%b want 1/0", cpu_run, busy);
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_start();
    vectors++;
    if (cpu_run !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_start_clears_run got=%b want=0", cpu_run);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    vectors++;
    if (cpu_run !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_done got run=%b busy=%b want 1/0", cpu_run, busy);
    end
    @(negedge clk);
    vectors++;
    if (wr_addr.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL zero_no_write got=%0d want=0", wr_addr.size());
    end
  endtask

  task automatic test_overflow();
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    vectors++;
    if (err !== 1'b1 || cpu_run !== 1'b0 || busy !== 1'b0 || wr_addr.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL overflow got err=%b run=%b busy=%b writes=%0d want 1/0/0/0",
               err, cpu_run, busy, wr_addr.size());
    end
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    @(negedge clk);
    vectors++;
    if (err !== 1'b0 || cpu_run !== 1'b1 || wr_addr.size() !== 1 ||
        wr_addr[0] !== 8'h00 || wr_data[0] !== 16'hCDAB) begin
      miscompares++;
      $display("[TB] FAIL overflow_recover got err=%b run=%b writes=%0d want 0/1/1 CDAB@00",
               err, cpu_run, wr_addr.size());
    end
  endtask

  // Full memory: N = 256, last write must land on 0xFF with no wrap write
  task automatic test_full();
    logic [7:0] b;
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send_byte(b, 0);
      send_byte(~b, 0);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (wr_addr.size() !== 256 || err !== 1'b0 || cpu_run !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_count got=%0d err=%b run=%b want 256/0/1",
               wr_addr.size(), err, cpu_run);
    end else begin
      for (int i = 0; i < 256; i++) begin
        b = 8'(i);
        vectors++;
        if (wr_addr[i] !== b || wr_data[i] !== {~b, b}) begin
          miscompares++;
          $display("[TB] FAIL full_write%0d got %h@%h want %h@%h",
                   i, wr_data[i], wr_addr[i], {~b, b}, b);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] s[8] = '{8'h03, 8'h00, 8'hEF, 8'hBE, 8'h0D, 8'hF0, 8'h55, 8'hAA};
    clear_log();
    pulse_start();
    foreach (s[i]) send_byte(s[i], $urandom_range(0, 3));
    @(negedge clk);
    vectors++;
    if (wr_addr.size() !== 3 ||
        wr_addr[0] !== 8'd0 || wr_data[0] !== 16'hBEEF ||
        wr_addr[1] !== 8'd1 || wr_data[1] !== 16'hF00D ||
        wr_addr[2] !== 8'd2 || wr_data[2] !== 16'hAA55) begin
      miscompares++;
      $display("[TB] FAIL gaps_writes got %0d writes want BEEF@0 F00D@1 AA55@2",
               wr_addr.size());
    end
    vectors++;
    if (ready_in_write !== 0) begin
      miscompares++;
      $display("[TB] FAIL gaps_ready_in_write got=%0d want=0", ready_in_write);
    end
    vectors++;
    if (cpu_run !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL gaps_done got=%b want=1", cpu_run);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'h10 + i), 0);
      send_byte(8'h77, 0);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({bus.in_ready, bus.mem_we, cpu_run, busy, err} !== 5'b0 ||
        bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL midreset_zero got flags=%b addr=%h data=%h want 0/00/0000",
               {bus.in_ready, bus.mem_we, cpu_run, busy, err}, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_log();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    repeat (6) @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if (wr_addr.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_idle got writes=%0d busy=%b want 0/0",
               wr_addr.size(), busy);
    end
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hA0, 0);
    send_byte(8'h02, 0);
    send_byte(8'hB0, 0);
    @(negedge clk);
    vectors++;
    if (wr_addr.size() !== 2 || wr_addr[0] !== 8'd0 || wr_data[0] !== 16'hA001 ||
        wr_addr[1] !== 8'd1 || wr_data[1] !== 16'hB002 || cpu_run !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_reload got %0d writes run=%b want A001@0 B002@1 run=1",
               wr_addr.size(), cpu_run);
    end
  endtask

  task automatic test_start_ignored();
    clear_log();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    // now in DAT_HI: pulse start together with the high byte
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h22;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 16'h2211) begin
      miscompares++;
      $display("[TB] FAIL start_ign_write got we=%b data=%h want 1/2211",
               bus.mem_we, bus.mem_wdata);
    end
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    @(negedge clk);
    vectors++;
    if (wr_addr.size() !== 2 || wr_addr[0] !== 8'd0 || wr_data[0] !== 16'h2211 ||
        wr_addr[1] !== 8'd1 || wr_data[1] !== 16'h4433 || cpu_run !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_ign_writes got %0d writes run=%b want 2211@0 4433@1 run=1",
               wr_addr.size(), cpu_run);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_full();
    test_gaps();
    test_reset_mid();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
